// File: rtl/opi_panel_sampler_if.sv
// Panel-side signal bundle for opi_panel_sampler: raw switches and lock request in, clean caps out.
// glitch_cnt_o exists only when OPI_GLITCH_CNT_EN is defined.
interface opi_panel_sampler_if;
  logic [1:0] sw_i;
  logic       lock_i;
  logic       puc_cap0_o;
  logic       puc_cap1_o;
  logic       valid_o;
  logic       locked_o;
`ifdef OPI_GLITCH_CNT_EN
  logic [7:0] glitch_cnt_o;

  modport master (output sw_i, output lock_i,
                  input puc_cap0_o, input puc_cap1_o, input valid_o, input locked_o,
                  input glitch_cnt_o);
  modport slave  (input sw_i, input lock_i,
                  output puc_cap0_o, output puc_cap1_o, output valid_o, output locked_o,
                  output glitch_cnt_o);
`else
  modport master (output sw_i, output lock_i,
                  input puc_cap0_o, input puc_cap1_o, input valid_o, input locked_o);
  modport slave  (input sw_i, input lock_i,
                  output puc_cap0_o, output puc_cap1_o, output valid_o, output locked_o);
`endif
endinterface

// File: rtl/opi_panel_sampler.sv
// Synchronises and debounces the two operator-panel capability switches and freezes them on lock.
// Optional saturating glitch counter enabled by OPI_GLITCH_CNT_EN.
//
// state  | meaning
// SETTLE | waiting for both debouncers to be quiet for DB_CYCLES; caps forced to 0
// RUN    | caps follow the debounced levels, valid_o=1
// LOCKED | caps frozen at their lock-time value until reset
module opi_panel_sampler #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 1024
) (
  input  logic               clk_i,
  input  logic               reset_i,
  opi_panel_sampler_if.slave pnl
);
  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] TC = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {ST_SETTLE, ST_RUN, ST_LOCKED} state_t;

  state_t           state, state_nxt;
  logic [1:0]       sync_q [SYNC_STAGES];
  logic [1:0]       syn;
  logic [1:0]       stb, stb_nxt;
  logic [CNT_W-1:0] db_cnt [2];
  logic [CNT_W-1:0] db_nxt [2];
  logic [CNT_W-1:0] settle_cnt;
  logic [1:0]       cap_q;

  assign syn = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= pnl.sw_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // A mismatch must persist for DB_CYCLES consecutive cycles before it is accepted.
  always_comb begin
    stb_nxt = stb;
    for (int n = 0; n < 2; n++) begin
      db_nxt[n] = db_cnt[n];
      if (syn[n] != stb[n]) begin
        if (db_cnt[n] == TC) begin
          stb_nxt[n] = syn[n];
          db_nxt[n]  = '0;
        end else begin
          db_nxt[n] = db_cnt[n] + CNT_W'(1);
        end
      end else if (db_cnt[n] != '0) begin
        db_nxt[n] = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      stb       <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      stb       <= stb_nxt;
      db_cnt[0] <= db_nxt[0];
      db_cnt[1] <= db_nxt[1];
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_SETTLE: if (settle_cnt == TC) state_nxt = ST_RUN;
      ST_RUN:    if (pnl.lock_i) state_nxt = ST_LOCKED;
      ST_LOCKED: state_nxt = ST_LOCKED;
      default:   state_nxt = ST_SETTLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state <= ST_SETTLE;
    else          state <= state_nxt;
  end

  // Caps load the next-cycle stb so they change on the same edge as the debounced level.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      settle_cnt <= '0;
      cap_q      <= '0;
    end else begin
      if (state == ST_SETTLE) begin
        if (db_cnt[0] == '0 && db_cnt[1] == '0) settle_cnt <= settle_cnt + CNT_W'(1);
        else                                    settle_cnt <= '0;
      end
      if (state_nxt == ST_SETTLE)  cap_q <= '0;
      else if (state != ST_LOCKED) cap_q <= stb_nxt;
    end
  end

  assign pnl.puc_cap0_o = cap_q[0];
  assign pnl.puc_cap1_o = cap_q[1];
  assign pnl.valid_o    = (state != ST_SETTLE);
  assign pnl.locked_o   = (state == ST_LOCKED);

`ifdef OPI_GLITCH_CNT_EN
  logic [1:0] rej;
  logic [7:0] glitch_q;
  logic [8:0] glitch_sum;

  always_comb begin
    for (int n = 0; n < 2; n++) rej[n] = (syn[n] == stb[n]) && (db_cnt[n] != '0);
    glitch_sum = {1'b0, glitch_q} + 9'(rej[0]) + 9'(rej[1]);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)          glitch_q <= '0;
    else if (glitch_sum[8]) glitch_q <= 8'hFF;
    else                   glitch_q <= glitch_sum[7:0];
  end

  assign pnl.glitch_cnt_o = glitch_q;
`endif
endmodule

// File: tb/tb_opi_panel_sampler.sv
// Scoreboard bench for opi_panel_sampler (SYNC_STAGES=2, DB_CYCLES=8): expected output changes
// are queued with the clock edge they must appear on; a monitor pops one per observed change.
module tb_opi_panel_sampler;
  localparam int SYNC = 2;
  localparam int DB   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  typedef struct {
    logic [3:0] vec;   // {valid, locked, cap1, cap0}
    int         at;
    string      nm;
  } exp_t;
  exp_t q[$];

  opi_panel_sampler_if pif ();

  opi_panel_sampler #(.SYNC_STAGES(SYNC), .DB_CYCLES(DB)) dut (
    .clk_i  (clk),
    .reset_i(rst_n),
    .pnl    (pif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] outs();
    return {pif.valid_o, pif.locked_o, pif.puc_cap1_o, pif.puc_cap0_o};
  endfunction

  task automatic expect_chg(string nm, logic [3:0] v, int at);
    q.push_back('{vec: v, at: at, nm: nm});
  endtask

  task automatic chk(string nm, logic [7:0] got, logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (cyc %0d)", nm, got, want, cyc);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every change of the output vector is a DUT presentation and must match the queue head.
  initial begin
    logic [3:0] prev, cur;
    exp_t e;
    prev = 4'b0000;
    forever begin
      @(negedge clk);
      cur = outs();
      if (cur !== prev) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change: got=%b at cyc %0d, want no change", cur, cyc);
        end else begin
          e = q.pop_front();
          if (cur !== e.vec || cyc != e.at) begin
            bad++;
            $display("FAIL %s: got=%b at cyc %0d, want=%b at cyc %0d", e.nm, cur, cyc, e.vec, e.at);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    int s;
    pif.sw_i   = 2'b00;
    pif.lock_i = 1'b0;

    // Reset state
    step(3);
    chk("reset_outs", {4'h0, outs()}, 8'h00);
`ifdef OPI_GLITCH_CNT_EN
    chk("reset_glitch", pif.glitch_cnt_o, 8'h00);
`endif

    // 1: release with switches low -> valid on the 8th edge after release
    rst_n = 1'b1;
    s = cyc;
    expect_chg("t1_valid", 4'b1000, s + DB);
    step(12);
    chk("t1_state", {4'h0, outs()}, 8'h08);

    // 2: clean 00->01; first sampling edge is s+1 and counts as clock 1 of SYNC+DB
    pif.sw_i = 2'b01;
    s = cyc;
    expect_chg("t2_cap0_rise", 4'b1001, s + SYNC + DB);
    step(14);

    // 3: 5-clock pulse on sw[1] is rejected
    pif.sw_i = 2'b11;
    step(5);
    pif.sw_i = 2'b01;
    step(5);
`ifdef OPI_GLITCH_CNT_EN
    chk("t3_glitch_one", pif.glitch_cnt_o, 8'h01);
`endif
    // both bits disagree for 5 clocks and reject on the same edge -> +2
    pif.sw_i = 2'b10;
    step(5);
    pif.sw_i = 2'b01;
    step(5);
`ifdef OPI_GLITCH_CNT_EN
    chk("t3_glitch_both", pif.glitch_cnt_o, 8'h03);
`endif
    for (int i = 0; i < 298; i++) begin
      pif.sw_i = 2'b11;
      step(5);
      pif.sw_i = 2'b01;
      step(5);
    end
`ifdef OPI_GLITCH_CNT_EN
    chk("t3_glitch_sat", pif.glitch_cnt_o, 8'hFF);
`endif
    chk("t3_caps", {4'h0, outs()}, 8'h09);

    // 4: settle 11, pulse lock, then panel goes to 00 while locked
    pif.sw_i = 2'b11;
    s = cyc;
    expect_chg("t4_cap1_rise", 4'b1011, s + SYNC + DB);
    step(14);
    pif.lock_i = 1'b1;
    s = cyc;
    expect_chg("t4_locked", 4'b1111, s + 1);
    step(1);
    pif.lock_i = 1'b0;
    pif.sw_i = 2'b00;
    step(50);
    chk("t4_frozen", {4'h0, outs()}, 8'h0F);

    // 5a: async reset from LOCKED
    #2 rst_n = 1'b0;
    s = cyc;
    expect_chg("t5_reset_drop", 4'b0000, s + 1);
    #1 chk("t5_async_zero", {4'h0, outs()}, 8'h00);
`ifdef OPI_GLITCH_CNT_EN
    chk("t5_glitch_clr", pif.glitch_cnt_o, 8'h00);
`endif
    step(2);
    rst_n = 1'b1;
    s = cyc;
    expect_chg("t5_valid_again", 4'b1000, s + DB);
    step(12);

    // 5b: reset while sw[0] debounce count is 4
    pif.sw_i = 2'b01;
    step(6);
    #2 rst_n = 1'b0;
    s = cyc;
    expect_chg("t5_mid_db_drop", 4'b0000, s + 1);
    #1 chk("t5_mid_db_zero", {4'h0, outs()}, 8'h00);
    pif.sw_i = 2'b00;
    step(2);
    rst_n = 1'b1;
    s = cyc;
    expect_chg("t5_valid_retn", 4'b1000, s + DB);
    step(12);

    // 6: lock held from reset, sw[0] toggles in SETTLE -> settle restarts, lock one edge after valid
    #2 rst_n = 1'b0;
    s = cyc;
    expect_chg("t6_reset_drop", 4'b0000, s + 1);
    pif.lock_i = 1'b1;
    pif.sw_i = 2'b00;
    step(2);
    rst_n = 1'b1;
    pif.sw_i = 2'b01;
    s = cyc;
    expect_chg("t6_valid", 4'b1000, s + 14);
    expect_chg("t6_locked", 4'b1100, s + 15);
    step(3);
    pif.sw_i = 2'b00;
    step(20);
`ifdef OPI_GLITCH_CNT_EN
    chk("t6_glitch", pif.glitch_cnt_o, 8'h01);
`endif
    chk("t6_final", {4'h0, outs()}, 8'h0C);

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL missing_changes: got %0d pending, want 0 (next %s)", q.size(), q[0].nm);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
